arb_rr_4to1: RTL and testbench

Round-robin arbiter that shares one 4-to-1 datapath mux among four requesters. It accepts per-requester request lines and grants exactly one owner at a time. It drives the mux 2-bit select directly from the registered owner index and holds the grant until the owner releases. The block sits in front of every shared 4-input mux in the pipeline, such as the writeback or forwarding source select, whenever more than one stage may claim it.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/arb_rr_4to1_pick.sv | 32 +++
 rtl/arb_rr_4to1.sv | 150 +++++++++++++++
 tb/tb_arb_rr_4to1.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count, select width and the one-hot to index helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Two-state controller; constants kept as plain localparams so older
  // tools and waveform scripts see stable encodings.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  // Convert a one-hot requester vector to its binary index (0 when not one-hot).
  function automatic logic [SEL_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_4to1_pick.sv
// rr_pick4: combinational round-robin winner search. Scans the masked request
// vector starting at ptr with modulo-4 wrap and returns the first set bit.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] excl,
  output logic       found,
  output logic [1:0] win_idx,
  output logic [3:0] win_oh
);

  logic [3:0] masked_s;
  logic [7:0] rot_wide_s;
  logic [3:0] rot_s;
  logic [3:0] lowest_s;
  logic [7:0] back_wide_s;

  // Rotate so the pointer lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    masked_s    = req & ~excl;
    rot_wide_s  = {masked_s, masked_s} >> ptr;
    rot_s       = rot_wide_s[3:0];
    lowest_s    = rot_s & (~rot_s + 4'd1);
    back_wide_s = {lowest_s, lowest_s} << ptr;
    win_oh      = back_wide_s[7:4];
    found       = |masked_s;
    win_idx     = oh2idx(back_wide_s[7:4]);
  end

endmodule

// File: rtl/arb_rr_4to1.sv
// arb_rr_4to1: round-robin arbiter driving the select of a shared 4:1 mux.
// Grant is held until the owner drops its request; handover is zero-bubble.
// Optional macro ARB_RR_TIMEOUT_EN adds a hold counter that forcibly releases
// an owner after MAX_HOLD cycles when another requester is waiting.
module arb_rr_4to1
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_busy,
  output logic       o_preempt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("arb_rr_4to1: MAX_HOLD must be in 2..255");
  end

  state_t     state_r, state_nx_s;
  logic [1:0] ptr_r, ptr_nx_s;
  logic [1:0] sel_r, sel_nx_s;
  logic [3:0] gnt_r, gnt_nx_s;
  logic       busy_r;
  logic       preempt_r, preempt_nx_s;

  logic [1:0] pick_ptr_s;
  logic [3:0] pick_excl_s;
  logic       found_s;
  logic [1:0] win_idx_s;
  logic [3:0] win_oh_s;
  logic       owner_req_s;
  logic       timeout_s;

  // While granted, search starts after the owner and never returns the owner.
  always_comb begin
    if (state_r == ST_GRANT) begin
      pick_ptr_s  = sel_r + 2'd1;
      pick_excl_s = 4'b0001 << sel_r;
    end else begin
      pick_ptr_s  = ptr_r;
      pick_excl_s = 4'b0000;
    end
  end

  rr_pick4 u_pick (
    .req     (i_req),
    .ptr     (pick_ptr_s),
    .excl    (pick_excl_s),
    .found   (found_s),
    .win_idx (win_idx_s),
    .win_oh  (win_oh_s)
  );

`ifdef ARB_RR_TIMEOUT_EN
  logic [7:0] hold_cnt_r;

  // Hold counter: clears on every new grant, counts in GRANT, saturates at the limit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hold_cnt_r <= 8'd0;
    end else if ((gnt_nx_s != 4'b0000) && (gnt_nx_s != gnt_r)) begin
      hold_cnt_r <= 8'd0;
    end else if ((state_r == ST_GRANT) && (hold_cnt_r != HOLD_LAST)) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  assign timeout_s = (hold_cnt_r == HOLD_LAST);
`else
  assign timeout_s = (HOLD_LAST == 8'd0);
`endif

  assign owner_req_s = |(i_req & gnt_r);

  // Next-state, pointer and grant decisions for the IDLE/GRANT controller.
  always_comb begin
    state_nx_s   = state_r;
    ptr_nx_s     = ptr_r;
    sel_nx_s     = sel_r;
    gnt_nx_s     = gnt_r;
    preempt_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nx_s = ST_GRANT;
          sel_nx_s   = win_idx_s;
          gnt_nx_s   = win_oh_s;
        end else begin
          gnt_nx_s   = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          ptr_nx_s = sel_r + 2'd1;
          if (found_s) begin
            sel_nx_s = win_idx_s;
            gnt_nx_s = win_oh_s;
          end else begin
            state_nx_s = ST_IDLE;
            gnt_nx_s   = 4'b0000;
          end
        end else if (timeout_s && found_s) begin
          ptr_nx_s     = sel_r + 2'd1;
          sel_nx_s     = win_idx_s;
          gnt_nx_s     = win_oh_s;
          preempt_nx_s = 1'b1;
        end else begin
          gnt_nx_s = gnt_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        gnt_nx_s   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 2'd0;
      sel_r     <= 2'd0;
      gnt_r     <= 4'b0000;
      busy_r    <= 1'b0;
      preempt_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ptr_r     <= ptr_nx_s;
      sel_r     <= sel_nx_s;
      gnt_r     <= gnt_nx_s;
      busy_r    <= |gnt_nx_s;
      preempt_r <= preempt_nx_s;
    end
  end

  assign o_gnt     = gnt_r;
  assign o_sel     = sel_r;
  assign o_busy    = busy_r;
  assign o_preempt = preempt_r;

endmodule

// File: tb/tb_arb_rr_4to1.sv
// Self-checking bench for arb_rr_4to1: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-free behavioural owner/pointer model.
// Honors ARB_RR_TIMEOUT_EN when defined (MAX_HOLD = 4 here).
module tb_arb_rr_4to1;

  localparam int MAX_HOLD = 4;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_req;
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_busy;
  logic       o_preempt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;
  bit m_pre;

  arb_rr_4to1 #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .o_gnt     (o_gnt),
    .o_sel     (o_sel),
    .o_busy    (o_busy),
    .o_preempt (o_preempt)
  );

  always #5 i_clk = ~i_clk;

  function automatic int pick(input logic [3:0] req, input int p, input int excl);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (req[k] && (k != excl)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_pre = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] req);
    int w;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      w = pick(req, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_sel = w; m_cnt = 0; end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(req, m_ptr, -1);
      m_owner = w;
      if (w >= 0) begin m_sel = w; m_cnt = 0; end
    end else begin
`ifdef ARB_RR_TIMEOUT_EN
      w = pick(req, (m_owner + 1) % 4, m_owner);
      if ((m_cnt == MAX_HOLD - 1) && (w >= 0)) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = w; m_sel = w; m_cnt = 0; m_pre = 1'b1;
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    logic [3:0] es;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    es = 4'(m_sel);
    chk("gnt", o_gnt, eg);
    chk("sel", {2'b00, o_sel}, es);
    chk("busy", {3'b000, o_busy}, {3'b000, (m_owner >= 0)});
    chk("preempt", {3'b000, o_preempt}, {3'b000, m_pre});
  endtask

  task automatic cycle(input logic [3:0] req);
    i_req = req;
    @(posedge i_clk);
    model_step(req);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_req = 4'b0000;
    #2 i_reset = 1'b1;
    model_reset();
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    check_all();
  endtask

  initial begin
    logic [3:0] r;
    i_reset = 1'b1;
    i_req   = 4'b0000;
    model_reset();
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;
    chk("rst_gnt", o_gnt, 4'b0000);
    chk("rst_sel", {2'b00, o_sel}, 4'd0);
    chk("rst_busy", {3'b000, o_busy}, 4'd0);

    // 0101: requester 0 first, then zero-bubble handover to 2
    cycle(4'b0101);
    chk("first_gnt", o_gnt, 4'b0001);
    cycle(4'b0100);
    chk("handover_gnt", o_gnt, 4'b0100);
    chk("handover_sel", {2'b00, o_sel}, 4'd2);
    cycle(4'b0000);

    // all four contend; order must be 0,1,2,3,0
    do_reset();
    for (int g = 0; g < 5; g++) begin
      repeat (3) cycle(4'b1111);
      chk("rr_order", {2'b00, o_sel}, 4'(g % 4));
      cycle(4'b1111 & ~(4'b0001 << (g % 4)));
    end
    cycle(4'b0000);
    cycle(4'b0000);

    // lone requester 3, release keeps sel, pointer wraps to 0
    do_reset();
    cycle(4'b1000);
    cycle(4'b0000);
    chk("idle_gnt", o_gnt, 4'b0000);
    chk("idle_sel", {2'b00, o_sel}, 4'd3);
    cycle(4'b1001);
    chk("wrap_gnt", o_gnt, 4'b0001);
    cycle(4'b0000);

    // asynchronous reset in the middle of owner 2's grant
    do_reset();
    cycle(4'b0100);
    cycle(4'b0100);
    #3 i_reset = 1'b1;
    model_reset();
    #1;
    chk("async_gnt", o_gnt, 4'b0000);
    chk("async_busy", {3'b000, o_busy}, 4'd0);
    check_all();
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    cycle(4'b1100);
    chk("post_rst_gnt", o_gnt, 4'b0100);
    cycle(4'b0000);

    // long hold with a waiter (preempts only with the timeout build)
    do_reset();
    cycle(4'b0010);
    repeat (8) cycle(4'b1010);
    cycle(4'b0000);
    // sole owner holds, then requester 0 appears
    do_reset();
    repeat (10) cycle(4'b0100);
    repeat (3) cycle(4'b0101);
    cycle(4'b0000);

    // random sticky traffic with an occasional reset
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
